// File: rtl/accum_pipe.sv
// Two-stage ADD/SUB/ACC/CLR unit with valid/ready on both sides; optional saturation via ACCUM_PIPE_SAT_EN.
// Latency 2 edges from acceptance to out_valid; in_ready drops only when both stages are full and out_ready is low.
module accum_pipe #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = WIDTH + 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [1:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_ovf,
  output logic [7:0]           out_count
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic                 r_s1_valid;
  logic [ACC_WIDTH-1:0] r_s1_a;
  logic [ACC_WIDTH-1:0] r_s1_b;
  logic [1:0]           r_s1_op;

  logic                 r_out_valid;
  logic [ACC_WIDTH-1:0] r_out_data;
  logic                 r_out_ovf;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [7:0]           r_count;

  logic                 w_move;
  logic                 w_in_xfer;
  logic [ACC_WIDTH-1:0] w_add;
  logic [ACC_WIDTH:0]   w_sub;
  logic [ACC_WIDTH:0]   w_acc_sum;
  logic [ACC_WIDTH-1:0] w_res;
  logic                 w_ovf;
  logic [ACC_WIDTH-1:0] w_acc_nxt;
  logic [7:0]           w_cnt_nxt;

  assign in_ready  = !r_s1_valid || !r_out_valid || out_ready;
  assign w_in_xfer = in_valid && in_ready;
  assign w_move    = r_s1_valid && (!r_out_valid || out_ready);

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;
  assign out_count = r_count;

  // Operands are zero-extended in S1, so the ADD sum always fits ACC_WIDTH.
  assign w_add     = r_s1_a + r_s1_b;
  assign w_sub     = {1'b0, r_s1_a} - {1'b0, r_s1_b};
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_s1_a};

  always_comb begin
    w_res     = '0;
    w_ovf     = 1'b0;
    w_acc_nxt = r_acc;
    w_cnt_nxt = r_count;
    case (r_s1_op)
      OP_ADD: w_res = w_add;
      OP_SUB: begin
        w_res = w_sub[ACC_WIDTH-1:0];
        w_ovf = w_sub[ACC_WIDTH];
`ifdef ACCUM_PIPE_SAT_EN
        if (w_sub[ACC_WIDTH]) w_res = '0;
`endif
      end
      OP_ACC: begin
        w_acc_nxt = w_acc_sum[ACC_WIDTH-1:0];
        w_ovf     = w_acc_sum[ACC_WIDTH];
`ifdef ACCUM_PIPE_SAT_EN
        if (w_acc_sum[ACC_WIDTH]) w_acc_nxt = '1;
`endif
        w_res     = w_acc_nxt;
        w_cnt_nxt = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
      end
      OP_CLR: begin
        w_acc_nxt = '0;
        w_cnt_nxt = '0;
      end
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= OP_ADD;
    end else if (w_in_xfer) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= {{(ACC_WIDTH-WIDTH){1'b0}}, in_a};
      r_s1_b     <= {{(ACC_WIDTH-WIDTH){1'b0}}, in_b};
      r_s1_op    <= in_op;
    end else if (w_move) begin
      r_s1_valid <= 1'b0;
    end
  end

  // acc and count live in S2 so back-to-back ACC beats see each other without bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      r_acc       <= '0;
      r_count     <= '0;
    end else if (w_move) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_res;
      r_out_ovf   <= w_ovf;
      r_acc       <= w_acc_nxt;
      r_count     <= w_cnt_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_accum_pipe.sv
// Bench for accum_pipe: directed scenarios plus randomized traffic against an arithmetic reference model.
module tb_accum_pipe;

  localparam int W  = 8;
  localparam int AW = 12;
  localparam int AMAX = (1 << AW) - 1;
`ifdef ACCUM_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [1:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          out_ovf;
  logic [7:0]    out_count;

  accum_pipe #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        o;
    logic [7:0]  c;
  } res_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];
  int   obs_d[$];
  int   obs_o[$];
  int   obs_c[$];
  int   m_acc = 0;
  int   m_cnt = 0;
  bit   rand_bp = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: result of a beat, computed in acceptance order.
  function automatic res_t model(input int op, input int a, input int b);
    res_t r;
    int s;
    r = '0;
    case (op)
      0: r.d = a + b;
      1: begin
        r.o = (a < b);
        if (a >= b)  r.d = a - b;
        else if (SAT) r.d = 0;
        else          r.d = a - b + (AMAX + 1);
      end
      2: begin
        s = m_acc + a;
        if (s > AMAX) begin
          r.o = 1'b1;
          m_acc = SAT ? AMAX : s - (AMAX + 1);
        end else begin
          m_acc = s;
        end
        if (m_cnt < 255) m_cnt++;
        r.d = m_acc;
      end
      default: begin
        m_acc = 0;
        m_cnt = 0;
      end
    endcase
    r.c = m_cnt[7:0];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check_eq("in_ready", {31'd0, in_ready}, {31'd0, (exp_q.size() < 2) || out_ready});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", {31'd0, out_valid}, 32'd0);
        end else begin
          check_eq("out_data",  {20'd0, out_data}, exp_q[0].d);
          check_eq("out_ovf",   {31'd0, out_ovf},  {31'd0, exp_q[0].o});
          check_eq("out_count", {24'd0, out_count}, {24'd0, exp_q[0].c});
          if (out_ready) begin
            obs_d.push_back(int'(out_data));
            obs_o.push_back(int'(out_ovf));
            obs_c.push_back(int'(out_count));
            void'(exp_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(int'(in_op), int'(in_a), int'(in_b)));
    end
  end

  task automatic clear_obs();
    obs_d.delete();
    obs_o.delete();
    obs_c.delete();
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bit rdy;
    int n = 0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      if (rdy) break;
      n++;
      if (n > 200) begin
        check_eq("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int last;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_op = 2'b00;
    out_ready = 1'b1;
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check_eq("rst_out_data",  {20'd0, out_data},  32'd0);
    check_eq("rst_out_count", {24'd0, out_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ADD latency: out_valid appears after the second edge following acceptance.
    send(2'b00, 8'd200, 8'd100);
    check_eq("lat_not_yet", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("lat_valid", {31'd0, out_valid}, 32'd1);
    check_eq("add_data",  {20'd0, out_data},  32'h12C);
    check_eq("add_ovf",   {31'd0, out_ovf},   32'd0);
    drain();

    send(2'b01, 8'd5, 8'd7);
    @(posedge clk);
    #1;
    check_eq("sub_data", {20'd0, out_data}, SAT ? 32'h000 : 32'hFFE);
    check_eq("sub_ovf",  {31'd0, out_ovf},  32'd1);
    drain();

    // CLR then 17 back-to-back ACC of 255.
    clear_obs();
    send(2'b11, 8'd0, 8'd0);
    for (int i = 0; i < 17; i++) send(2'b10, 8'd255, 8'd0);
    drain();
    check_eq("acc_n_results", obs_d.size(), 32'd18);
    if (obs_d.size() == 18) begin
      check_eq("acc16_data",  obs_d[16], 32'hFF0);
      check_eq("acc16_ovf",   obs_o[16], 32'd0);
      check_eq("acc16_count", obs_c[16], 32'd16);
      check_eq("acc17_data",  obs_d[17], SAT ? 32'hFFF : 32'h0EF);
      check_eq("acc17_ovf",   obs_o[17], 32'd1);
      check_eq("acc17_count", obs_c[17], 32'd17);
    end

    // Backpressure: 5 stalled cycles offering (1,1),(2,2),(3,3).
    clear_obs();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_op = 2'b00;
      in_a = 8'(idx + 1);
      in_b = 8'(idx + 1);
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk);
      #1;
    end
    check_eq("bp_accepted", idx, 32'd2);
    check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("bp_held",     {20'd0, out_data}, 32'd2);
    out_ready = 1'b1;
    send(2'b00, 8'd3, 8'd3);
    drain();
    check_eq("bp_n_results", obs_d.size(), 32'd3);
    if (obs_d.size() == 3) begin
      check_eq("bp_res0", obs_d[0], 32'd2);
      check_eq("bp_res1", obs_d[1], 32'd4);
      check_eq("bp_res2", obs_d[2], 32'd6);
    end

    // Reset with both stages full.
    out_ready = 1'b0;
    send(2'b10, 8'd9, 8'd0);
    send(2'b10, 8'd9, 8'd0);
    #2 rst = 1'b1;
    exp_q.delete();
    m_acc = 0;
    m_cnt = 0;
    #1;
    check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_out_data",  {20'd0, out_data},  32'd0);
    check_eq("midrst_out_count", {24'd0, out_count}, 32'd0);
    check_eq("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    clear_obs();
    send(2'b10, 8'd3, 8'd0);
    drain();
    check_eq("postrst_n", obs_d.size(), 32'd1);
    if (obs_d.size() == 1) begin
      check_eq("postrst_data",  obs_d[0], 32'd3);
      check_eq("postrst_count", obs_c[0], 32'd1);
    end

    // Count saturation.
    send(2'b11, 8'd0, 8'd0);
    for (int i = 0; i < 300; i++) send(2'b10, 8'd0, 8'd0);
    drain();
    last = obs_c.size() - 1;
    check_eq("sat_count", obs_c[last], 32'd255);
    check_eq("sat_data",  obs_d[last], 32'd0);
    send(2'b11, 8'd0, 8'd0);
    drain();
    check_eq("clr_count", {24'd0, out_count}, 32'd0);

    // Randomized traffic with random backpressure and idle gaps.
    rand_bp = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1 out_ready = ($urandom_range(0, 3) != 0);
      end
      idx = $urandom_range(0, 9);
      send((idx < 5) ? 2'b10 : (idx < 7) ? 2'b00 : (idx < 9) ? 2'b01 : 2'b11,
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    rand_bp = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
